gray_step_monitor: RTL and testbench



---
 rtl/gray_step_monitor.sv | 110 +++++++++++
 tb/tb_gray_step_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - Gray counter step monitor: decodes gray_in and flags illegal steps
// Optional error counter port err_count enabled by `define GRAY_STEP_ERR_CNT_EN.
module gray_step_monitor #(
  parameter int N      = 4,
  parameter int RESYNC = 2
`ifdef GRAY_STEP_ERR_CNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] gray_in,
  input  logic         clear_err,
  output logic [N-1:0] bin_out,
  output logic         bin_valid,
  output logic         step_err,
  output logic         err_sticky,
  output logic         in_fault
`ifdef GRAY_STEP_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;
  localparam logic [3:0] RESYNC_C = 4'(RESYNC);

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [1:0]   state;
  logic [N-1:0] prev_gray;
  logic [3:0]   good_cnt;
  logic [N-1:0] in_bin;
  logic [N-1:0] prev_bin_inc;
  logic         legal;
  logic         err_hit;

  assign in_bin       = gray2bin(gray_in);
  assign prev_bin_inc = gray2bin(prev_gray) + N'(1);
  assign legal        = (gray_in == prev_gray) || (in_bin == prev_bin_inc);
  assign err_hit      = enable && (state != S_INIT) && !legal;
  assign in_fault     = (state == S_FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      prev_gray  <= '0;
      good_cnt   <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step_err <= err_hit;
      // an error on the same edge as clear_err keeps the flag set
      if (err_hit)        err_sticky <= 1'b1;
      else if (clear_err) err_sticky <= 1'b0;

      if (enable) begin
        prev_gray <= gray_in;
        bin_out   <= in_bin;
        case (state)
          S_INIT: begin
            bin_valid <= 1'b1;
            state     <= S_TRACK;
          end
          S_TRACK: begin
            if (!legal) begin
              good_cnt <= '0;
              state    <= S_FAULT;
            end
          end
          default: begin
            if (!legal) begin
              good_cnt <= '0;
            end else if (good_cnt + 4'd1 == RESYNC_C) begin
              good_cnt <= '0;
              state    <= S_TRACK;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef GRAY_STEP_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_hit) begin
      if (clear_err)              err_count <= CNT_W'(1);
      else if (err_count != '1)   err_count <= err_count + CNT_W'(1);
    end else if (clear_err) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - randomized and directed self-checking bench for gray_step_monitor
module tb_gray_step_monitor;
  localparam int N      = 4;
  localparam int RESYNC = 2;
  localparam int CNT_W  = 2;
  localparam int MODN   = 1 << N;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] gray_in;
  logic         clear_err;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic         step_err;
  logic         err_sticky;
  logic         in_fault;
`ifdef GRAY_STEP_ERR_CNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  gray_step_monitor #(
    .N(N),
    .RESYNC(RESYNC)
`ifdef GRAY_STEP_ERR_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .gray_in(gray_in),
    .clear_err(clear_err),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .step_err(step_err),
    .err_sticky(err_sticky),
    .in_fault(in_fault)
`ifdef GRAY_STEP_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: counts as plain integers
  int m_prev_g, m_bin, m_good, m_cnt;
  bit m_valid, m_fault, m_sticky, m_step;
  int ctr;

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) % MODN;
  endfunction

  function automatic int to_bin(int g);
    int b = 0;
    for (int s = 0; s < N; s++) b = b ^ (g >> s);
    return b % MODN;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_g = 0; m_bin = 0; m_good = 0; m_cnt = 0;
    m_valid = 0; m_fault = 0; m_sticky = 0; m_step = 0;
  endtask

  task automatic model_step(input bit en, input int g, input bit clr);
    bit e = 0;
    if (en) begin
      if (!m_valid) begin
        m_valid = 1;
      end else if (g == m_prev_g || to_bin(g) == (to_bin(m_prev_g) + 1) % MODN) begin
        if (m_fault) begin
          m_good++;
          if (m_good == RESYNC) begin m_fault = 0; m_good = 0; end
        end
      end else begin
        e = 1; m_fault = 1; m_good = 0;
      end
      m_prev_g = g;
      m_bin    = to_bin(g);
    end
    m_step = e;
    if (e) begin
      m_sticky = 1;
      m_cnt = clr ? 1 : ((m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt);
    end else if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
  endtask

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("bin_valid", 32'(bin_valid), 32'(m_valid));
      chk("step_err", 32'(step_err), 32'(m_step));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("in_fault", 32'(in_fault), 32'(m_fault));
`ifdef GRAY_STEP_ERR_CNT_EN
      chk("err_count", 32'(err_count), 32'(m_cnt));
`endif
    end
  end

  task automatic drive(input bit en, input logic [N-1:0] g, input bit clr);
    enable = en; gray_in = g; clear_err = clr;
    @(posedge clk);
    model_step(en, int'(g), clr);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_bin_out"}, 32'(bin_out), 0);
    chk({nm, "_bin_valid"}, 32'(bin_valid), 0);
    chk({nm, "_step_err"}, 32'(step_err), 0);
    chk({nm, "_err_sticky"}, 32'(err_sticky), 0);
    chk({nm, "_in_fault"}, 32'(in_fault), 0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_zero("async_rst");
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; gray_in = '0; clear_err = 1'b0;
    model_reset();
    #12;
    check_zero("por");
    reset = 1'b0;
    cmp_on = 1;

    // counting with each code held for two samples, including the 15 -> 0 wrap
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, N'(to_gray((i / 2) % MODN)), 1'b0);
      if (i == 0)  chk("first_valid", 32'(bin_valid), 1);
      if (i == 31) chk("cnt_bin15", 32'(bin_out), 15);
      if (i == 32) begin
        chk("wrap_bin0", 32'(bin_out), 0);
        chk("wrap_no_err", 32'(step_err), 0);
      end
    end

    do_reset();
    drive(1'b1, 4'b0011, 1'b0);
    drive(1'b1, 4'b0101, 1'b0);
    chk("skip_step_err", 32'(step_err), 1);
    chk("skip_sticky", 32'(err_sticky), 1);
    chk("skip_fault", 32'(in_fault), 1);
    chk("skip_bin6", 32'(bin_out), 6);
    drive(1'b1, 4'b0100, 1'b0);
    chk("resync1_pulse_end", 32'(step_err), 0);
    chk("resync1_fault", 32'(in_fault), 1);
    chk("resync1_bin7", 32'(bin_out), 7);
    drive(1'b1, 4'b1100, 1'b0);
    chk("resync2_track", 32'(in_fault), 0);
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b0111, 1'b0);
    chk("restart_err", 32'(step_err), 1);
    chk("restart_fault", 32'(in_fault), 1);
    drive(1'b1, 4'b0101, 1'b0);
    chk("restart_one_legal", 32'(in_fault), 1);
    drive(1'b1, 4'b0100, 1'b0);
    chk("restart_track", 32'(in_fault), 0);

    do_reset();
    drive(1'b1, 4'b0110, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    chk("backward_err", 32'(step_err), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, N'($urandom_range(0, MODN - 1)), 1'b0);
      chk("disabled_no_err", 32'(step_err), 0);
      chk("disabled_hold_bin", 32'(bin_out), 3);
    end
    drive(1'b1, 4'b1111, 1'b1);
    chk("clr_vs_err_sticky", 32'(err_sticky), 1);
    drive(1'b0, 4'b1111, 1'b1);
    chk("clr_alone_sticky", 32'(err_sticky), 0);

`ifdef GRAY_STEP_ERR_CNT_EN
    do_reset();
    drive(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, (i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
    chk("err_count_sat", 32'(err_count), 3);
    drive(1'b0, 4'b0000, 1'b1);
    chk("err_count_clr", 32'(err_count), 0);
`endif

    do_reset();
    for (int b = 0; b <= 9; b++) drive(1'b1, N'(to_gray(b)), 1'b0);
    chk("pre_rst_bin9", 32'(bin_out), 9);
    do_reset();
    drive(1'b1, 4'b1101, 1'b0);
    chk("post_rst_no_err", 32'(step_err), 0);
    chk("post_rst_valid", 32'(bin_valid), 1);
    chk("post_rst_bin9", 32'(bin_out), 9);

    // randomized traffic: mostly counting, with holds, jumps, clears and resets
    ctr = 9;
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 9);
      int g;
      if (r < 6)      begin ctr = (ctr + 1) % MODN; g = to_gray(ctr); end
      else if (r < 8) g = to_gray(ctr);
      else            begin g = $urandom_range(0, MODN - 1); end
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        bit en = ($urandom_range(0, 7) != 0);
        drive(en, N'(g), $urandom_range(0, 15) == 0);
        if (en) ctr = to_bin(g);
      end
    end

    cmp_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
